jk_excitation_driver: RTL and testbench



---
 rtl/jk_excitation_driver_if.sv | 25 ++
 rtl/jk_excitation_driver.sv | 130 +++++++++++++
 tb/tb_jk_excitation_driver.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/jk_excitation_driver_if.sv
// Handshake and drive/feedback bundle between the sequencer and a bank of JK flip-flops.
interface jk_excitation_driver_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] target;
  logic             target_valid;
  logic             ready;
  logic [WIDTH-1:0] q_fb;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic             busy;
  logic             done;
  logic             err;
  logic [WIDTH-1:0] mismatch;

  modport master (
    output target, target_valid, q_fb,
    input  ready, j, k, busy, done, err, mismatch
  );

  modport slave (
    input  target, target_valid, q_fb,
    output ready, j, k, busy, done, err, mismatch
  );
endinterface

// File: rtl/jk_excitation_driver.sv
// Drives J/K for a bank of external JK flip-flops toward a requested state,
// verifies the bank after a settle delay and retries a bounded number of times.
//
// state   | meaning
// IDLE    | ready for a target; j/k held at 0
// DRIVE   | j/k asserted for exactly one clock
// WAIT    | settle countdown, SETTLE cycles
// CHECK   | compare q_fb with latched target; finish or retry
module jk_excitation_driver #(
  parameter int WIDTH      = 4,
  parameter int SETTLE     = 1,
  parameter int MAX_RETRY  = 2,
  parameter int USE_TOGGLE = 0
) (
  input logic                   clk,
  input logic                   rst,
  jk_excitation_driver_if.slave bus_if
);

  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_WAIT, S_CHECK} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic [WIDTH-1:0] j_q, j_d;
  logic [WIDTH-1:0] k_q, k_d;
  logic [WIDTH-1:0] mism_q, mism_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [RW-1:0]    retry_q, retry_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] exc_tgt, exc_j, exc_k;

  // In IDLE the excitation is formed from the incoming target so j/k can be
  // registered on the accept edge; afterwards from the latched target.
  always_comb begin
    exc_tgt = (state_q == S_IDLE) ? bus_if.target : tgt_q;
    if (USE_TOGGLE != 0) begin
      exc_j = exc_tgt ^ bus_if.q_fb;
      exc_k = exc_tgt ^ bus_if.q_fb;
    end else begin
      exc_j = exc_tgt & ~bus_if.q_fb;
      exc_k = ~exc_tgt & bus_if.q_fb;
    end
  end

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    j_d     = '0;
    k_d     = '0;
    mism_d  = mism_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus_if.target_valid) begin
          tgt_d   = bus_if.target;
          j_d     = exc_j;
          k_d     = exc_k;
          mism_d  = '0;
          retry_d = '0;
          state_d = S_DRIVE;
        end
      end
      S_DRIVE: begin
        cnt_d   = 4'(SETTLE);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = S_CHECK;
      end
      S_CHECK: begin
        mism_d = tgt_q ^ bus_if.q_fb;
        if (bus_if.q_fb == tgt_q) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (retry_q < RW'(MAX_RETRY)) begin
          retry_d = retry_q + RW'(1);
          j_d     = exc_j;
          k_d     = exc_k;
          state_d = S_DRIVE;
        end else begin
          done_d  = 1'b1;
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      tgt_q   <= '0;
      j_q     <= '0;
      k_q     <= '0;
      mism_q  <= '0;
      cnt_q   <= '0;
      retry_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      j_q     <= j_d;
      k_q     <= k_d;
      mism_q  <= mism_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus_if.ready    = (state_q == S_IDLE);
  assign bus_if.busy     = (state_q != S_IDLE);
  assign bus_if.j        = j_q;
  assign bus_if.k        = k_q;
  assign bus_if.done     = done_q;
  assign bus_if.err      = err_q;
  assign bus_if.mismatch = mism_q;

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Directed bench: two driver instances (set/reset and toggle flavours) each
// steering a behavioural JK bank, with per-cycle expected values.
module tb_jk_excitation_driver;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  jk_excitation_driver_if #(.WIDTH(4)) ifa ();
  jk_excitation_driver_if #(.WIDTH(4)) ifb ();

  jk_excitation_driver #(.WIDTH(4), .SETTLE(1), .MAX_RETRY(2), .USE_TOGGLE(0)) u_dut_a (
    .clk    (clk),
    .rst    (rst),
    .bus_if (ifa)
  );

  jk_excitation_driver #(.WIDTH(4), .SETTLE(3), .MAX_RETRY(2), .USE_TOGGLE(1)) u_dut_b (
    .clk    (clk),
    .rst    (rst),
    .bus_if (ifb)
  );

  // JK characteristic equation: q+ = j&~q | ~k&q
  function automatic logic [3:0] jk_next(input logic [3:0] q, input logic [3:0] j,
                                         input logic [3:0] k);
    return (j & ~q) | (~k & q);
  endfunction

  logic       load_a, load_b;
  logic [3:0] load_val_a, load_val_b, stuck_a;

  always @(posedge clk) begin
    if (load_a) ifa.q_fb <= load_val_a & ~stuck_a;
    else        ifa.q_fb <= jk_next(ifa.q_fb, ifa.j, ifa.k) & ~stuck_a;
  end

  always @(posedge clk) begin
    if (load_b) ifb.q_fb <= load_val_b;
    else        ifb.q_fb <= jk_next(ifb.q_fb, ifb.j, ifb.k);
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic load_bank_a(input logic [3:0] v);
    load_val_a = v;
    load_a     = 1'b1;
    cyc();
    load_a     = 1'b0;
  endtask

  task automatic start_a(input logic [3:0] t);
    ifa.target       = t;
    ifa.target_valid = 1'b1;
    cyc();
    ifa.target_valid = 1'b0;
  endtask

  logic [3:0] tbl [13] = '{4'b0101, 4'b1111, 4'b0000, 4'b0011, 4'b1000, 4'b0110, 4'b1001,
                           4'b0000, 4'b1111, 4'b0111, 4'b0001, 4'b1110, 4'b0100};

  initial begin
    rst              = 1'b1;
    ifa.target       = '0;
    ifa.target_valid = 1'b0;
    ifb.target       = '0;
    ifb.target_valid = 1'b0;
    stuck_a          = '0;
    load_val_a       = 4'b0000;
    load_val_b       = 4'b1100;
    load_a           = 1'b1;
    load_b           = 1'b1;
    cyc();
    cyc();
    rst    = 1'b0;
    load_a = 1'b0;
    load_b = 1'b0;

    // reset state
    chk("rst_ready", ifa.ready, 1);
    chk("rst_busy", ifa.busy, 0);
    chk("rst_j", ifa.j, 0);
    chk("rst_k", ifa.k, 0);
    chk("rst_done", ifa.done, 0);
    chk("rst_err", ifa.err, 0);
    chk("rst_mism", ifa.mismatch, 0);

    // 0000 -> 1010 set/reset
    start_a(4'b1010);
    chk("t1_c1_j", ifa.j, 4'b1010);
    chk("t1_c1_k", ifa.k, 4'b0000);
    chk("t1_c1_busy", ifa.busy, 1);
    chk("t1_c1_ready", ifa.ready, 0);
    cyc();
    chk("t1_c2_jk", {ifa.j, ifa.k}, 8'h00);
    cyc();
    chk("t1_c3_jk", {ifa.j, ifa.k}, 8'h00);
    chk("t1_c3_done", ifa.done, 0);
    cyc();
    chk("t1_c4_done", ifa.done, 1);
    chk("t1_c4_err", ifa.err, 0);
    chk("t1_c4_mism", ifa.mismatch, 4'b0000);
    chk("t1_c4_ready", ifa.ready, 1);
    chk("t1_c4_q", ifa.q_fb, 4'b1010);
    cyc();
    chk("t1_c5_done", ifa.done, 0);

    // bit0 stuck at 0: three drive attempts then err
    stuck_a = 4'b0001;
    load_bank_a(4'b0000);
    start_a(4'b0001);
    for (int c = 1; c <= 10; c++) begin
      chk($sformatf("t3_c%0d_j", c), ifa.j, (c == 1 || c == 4 || c == 7) ? 4'b0001 : 4'b0000);
      chk($sformatf("t3_c%0d_k", c), ifa.k, 4'b0000);
      chk($sformatf("t3_c%0d_done", c), ifa.done, (c == 10) ? 1 : 0);
      chk($sformatf("t3_c%0d_err", c), ifa.err, (c == 10) ? 1 : 0);
      if (c == 10) chk("t3_mism", ifa.mismatch, 4'b0001);
      if (c < 10) cyc();
    end
    cyc();
    stuck_a = 4'b0000;

    // target already equal to bank
    load_bank_a(4'b0110);
    start_a(4'b0110);
    chk("t4_c1_jk", {ifa.j, ifa.k}, 8'h00);
    chk("t4_c1_busy", ifa.busy, 1);
    cyc();
    cyc();
    cyc();
    chk("t4_c4_done", ifa.done, 1);
    chk("t4_c4_err", ifa.err, 0);
    cyc();

    // reset during WAIT
    load_bank_a(4'b0000);
    start_a(4'b1111);
    chk("t5_c1_j", ifa.j, 4'b1111);
    cyc();
    chk("t5_c2_busy", ifa.busy, 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("t5_rst_jk", {ifa.j, ifa.k}, 8'h00);
    chk("t5_rst_busy", ifa.busy, 0);
    chk("t5_rst_ready", ifa.ready, 1);
    chk("t5_rst_done", ifa.done, 0);
    cyc();
    chk("t5_after_done", ifa.done, 0);
    start_a(4'b0000);
    chk("t5b_c1_j", ifa.j, 4'b0000);
    chk("t5b_c1_k", ifa.k, 4'b1111);
    cyc();
    cyc();
    cyc();
    chk("t5b_c4_done", ifa.done, 1);
    chk("t5b_c4_err", ifa.err, 0);
    chk("t5b_c4_q", ifa.q_fb, 4'b0000);

    // toggle flavour, SETTLE=3: 1100 -> 1010
    ifb.target       = 4'b1010;
    ifb.target_valid = 1'b1;
    cyc();
    ifb.target_valid = 1'b0;
    chk("t2_c1_j", ifb.j, 4'b0110);
    chk("t2_c1_k", ifb.k, 4'b0110);
    for (int c = 2; c <= 5; c++) begin
      cyc();
      chk($sformatf("t2_c%0d_done", c), ifb.done, 0);
      chk($sformatf("t2_c%0d_jk", c), {ifb.j, ifb.k}, 8'h00);
    end
    cyc();
    chk("t2_c6_done", ifb.done, 1);
    chk("t2_c6_err", ifb.err, 0);
    chk("t2_c6_mism", ifb.mismatch, 4'b0000);
    chk("t2_c6_q", ifb.q_fb, 4'b1010);

    // valid held high with a changing target
    cyc();
    for (int c = 0; c <= 12; c++) begin
      if (c == 0) chk("t6_c0_ready", ifb.ready, 1);
      if (c == 1) chk("t6_c1_jk", {ifb.j, ifb.k}, 8'hFF);
      if (c >= 2 && c <= 5) begin
        chk($sformatf("t6_c%0d_ready", c), ifb.ready, 0);
        chk($sformatf("t6_c%0d_j", c), ifb.j, 4'b0000);
        chk($sformatf("t6_c%0d_done", c), ifb.done, 0);
      end
      if (c == 6) begin
        chk("t6_c6_done", ifb.done, 1);
        chk("t6_c6_ready", ifb.ready, 1);
        chk("t6_c6_q", ifb.q_fb, 4'b0101);
      end
      if (c == 7) chk("t6_c7_jk", {ifb.j, ifb.k}, 8'hCC);
      if (c == 12) begin
        chk("t6_c12_done", ifb.done, 1);
        chk("t6_c12_err", ifb.err, 0);
        chk("t6_c12_q", ifb.q_fb, 4'b1001);
      end
      ifb.target       = tbl[c];
      ifb.target_valid = (c < 12);
      cyc();
    end
    chk("t6_c13_busy", ifb.busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
